// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC fetch path.
//   - fetch FSM state encoding (fetch_state_e)
//   - default PC / instruction widths and instruction buffer depth
//   - PC value loaded on reset
package sisc_pkg;

  localparam int unsigned PC_W_DEF       = 16;
  localparam int unsigned INSTR_W_DEF    = 32;
  localparam int unsigned IBUF_DEPTH_DEF = 2;
  localparam int unsigned RESET_PC       = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // A memory request is outstanding in REQ and in DROP.
  function automatic logic is_req_state(input fetch_state_e s);
    return (s == ST_REQ) || (s == ST_DROP);
  endfunction

endpackage

// File: rtl/fetch_unit_ibuf.sv
// ibuf: synchronous FIFO of {pc, instr} entries feeding decode.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   push, push_pc,
//   push_instr        - write one entry (accepted when not full, or full with a pop)
//   pop               - drop the head entry (ignored when empty)
//   flush             - empty the FIFO; wins over push
//   head_pc, head_instr - head entry, read from registered storage
//   full, empty, count  - occupancy
module ibuf #(
  parameter  int unsigned PC_W    = 16,
  parameter  int unsigned INSTR_W = 32,
  parameter  int unsigned DEPTH   = 2,
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]    pc_mem_q  [DEPTH];
  logic [PC_W-1:0]    pc_mem_d  [DEPTH];
  logic [INSTR_W-1:0] ins_mem_q [DEPTH];
  logic [INSTR_W-1:0] ins_mem_d [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_pc    = pc_mem_q[rd_ptr_q[AW-1:0]];
  assign head_instr = ins_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pc_mem_d  = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        pc_mem_d[wr_ptr_q[AW-1:0]]  = push_pc;
        ins_mem_d[wr_ptr_q[AW-1:0]] = push_instr;
        wr_ptr_d                    = wr_ptr_q + CNT_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pc_mem_q  <= pc_mem_d;
      ins_mem_q <= ins_mem_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: SISC instruction fetch stage. Owns the program counter,
// issues one-at-a-time word requests to instruction memory and buffers the
// returned words for decode.
// Ports:
//   clk, rst_f             - clock, asynchronous active-high reset
//   imem_req, imem_addr    - memory request and its word address (held until ack)
//   imem_ack, imem_data    - request complete, data valid in the same cycle
//   ir, ir_pc, ir_valid    - head instruction, its address, valid flag
//   ir_ready               - decode takes the head when ir_valid && ir_ready
//   br_taken, br_target    - one-cycle redirect strobe and target address
//   halt                   - level; no new requests while high
// Build option:
//   FETCH_PREFETCH_EN      - issue whenever a buffer slot is free; otherwise
//                            issue only once the buffer is (becoming) empty.
module fetch_unit import sisc_pkg::*; #(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned INSTR_W    = INSTR_W_DEF,
  parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_f,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               halt
);

  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH) + 1;
`ifdef FETCH_PREFETCH_EN
  localparam int unsigned ISSUE_CAP = IBUF_DEPTH;
`else
  localparam int unsigned ISSUE_CAP = 1;
`endif

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  addr_q, addr_d;

  logic             push;
  logic             pop;
  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] cnt_after;
  logic             space_ok;

  assign imem_req  = is_req_state(state_q);
  assign imem_addr = addr_q;
  assign ir_valid  = !buf_empty;
  assign pop       = ir_valid && ir_ready;

  // Acked data is kept only in REQ and only when no redirect arrives with it.
  assign push = (state_q == ST_REQ) && imem_ack && !br_taken && (!buf_full || pop);

  // Occupancy after this cycle's push/pop/flush decides whether the next
  // request may be issued; a redirect always leaves the buffer empty.
  assign cnt_after = br_taken ? '0 : (buf_count + CNT_W'(push) - CNT_W'(pop));
  assign space_ok  = (cnt_after < CNT_W'(ISSUE_CAP));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;

    if (br_taken) begin
      fetch_pc_d = br_target;
    end

    case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (space_ok) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_d;
        end
      end

      ST_REQ, ST_DROP: begin
        if (imem_ack) begin
          if (state_q == ST_REQ && !br_taken) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
          end
          // Back-to-back issue straight from the ack cycle keeps 1 word/cycle.
          if (halt) begin
            state_d = ST_HALTED;
          end else if (space_ok) begin
            state_d = ST_REQ;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (br_taken) begin
          // Request still in flight: keep its address, throw its data away.
          state_d = ST_DROP;
        end
      end

      ST_HALTED: begin
        if (!halt) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= PC_W'(RESET_PC);
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  ibuf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (IBUF_DEPTH)
  ) u_ibuf (
    .clk        (clk),
    .rst        (rst_f),
    .push       (push),
    .push_pc    (fetch_pc_q),
    .push_instr (imem_data),
    .pop        (pop),
    .flush      (br_taken),
    .head_pc    (ir_pc),
    .head_instr (ir),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count)
  );

endmodule
